// File: rtl/move_gen_seq.sv
// rtl/move_gen_seq.sv - sequential pseudo-legal move enumerator, one target square per handshake
// Optional occupancy blocking is enabled by defining MOVE_GEN_BLOCKER_EN.
module move_gen_seq #(
    parameter int BOARD_DIM = 8,
    parameter int SQ_W      = $clog2(BOARD_DIM * BOARD_DIM)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [3:0]                     piece,
    input  logic                           player,
    input  logic [SQ_W-1:0]                square,
`ifdef MOVE_GEN_BLOCKER_EN
    input  logic [BOARD_DIM*BOARD_DIM-1:0] occ,
`endif
    output logic                           move_valid,
    input  logic                           move_ready,
    output logic [SQ_W-1:0]                move_sq,
    output logic                           gen_done,
    output logic [SQ_W-1:0]                move_count,
    output logic                           busy
);
    localparam int RW = SQ_W / 2 + 2;
    localparam logic signed [RW-1:0] DIM_S   = RW'(BOARD_DIM);
    localparam logic signed [RW-1:0] START_W = RW'(1);
    localparam logic signed [RW-1:0] START_B = RW'(BOARD_DIM - 2);
    localparam logic [SQ_W-1:0]      DIM_U   = SQ_W'(BOARD_DIM);

    localparam logic [2:0] P1 = 3'b001, P2 = 3'b010, Z0 = 3'b000, M1 = 3'b111, M2 = 3'b110;

    localparam logic [3:0] PC_PAWN   = 4'd1;
    localparam logic [3:0] PC_ROOK   = 4'd2;
    localparam logic [3:0] PC_KNIGHT = 4'd3;
    localparam logic [3:0] PC_BISHOP = 4'd4;
    localparam logic [3:0] PC_QUEEN  = 4'd5;

`ifdef MOVE_GEN_BLOCKER_EN
    localparam logic CAPT_NEEDS_OCC = 1'b1;
`else
    localparam logic CAPT_NEEDS_OCC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WALK, EMIT, DONE} state_t;

    state_t               state;
    logic [3:0]           pc;
    logic                 pl;
    logic signed [RW-1:0] org_r, org_f, cur_r, cur_f;
    logic [2:0]           idx;
    logic                 last_pending;
    logic                 push1_clear;

    // Step vector {dr, df} in 3-bit two's complement for the current candidate index.
    function automatic logic [5:0] delta(input logic [3:0] p, input logic side, input logic [2:0] i);
        logic [2:0] fw1, fw2;
        fw1 = side ? M1 : P1;
        fw2 = side ? M2 : P2;
        if (p == PC_KNIGHT) begin
            case (i)
                3'd0:    delta = {P2, P1};
                3'd1:    delta = {P1, P2};
                3'd2:    delta = {M1, P2};
                3'd3:    delta = {M2, P1};
                3'd4:    delta = {M2, M1};
                3'd5:    delta = {M1, M2};
                3'd6:    delta = {P1, M2};
                default: delta = {P2, M1};
            endcase
        end else if (p == PC_PAWN) begin
            case (i[1:0])
                2'd0:    delta = {fw1, Z0};
                2'd1:    delta = {fw2, Z0};
                2'd2:    delta = {fw1, M1};
                default: delta = {fw1, P1};
            endcase
        end else begin
            case (i)
                3'd0:    delta = {P1, Z0};
                3'd1:    delta = {Z0, P1};
                3'd2:    delta = {M1, Z0};
                3'd3:    delta = {Z0, M1};
                3'd4:    delta = {P1, P1};
                3'd5:    delta = {M1, P1};
                3'd6:    delta = {M1, M1};
                default: delta = {P1, M1};
            endcase
        end
    endfunction

    logic [5:0]           d;
    logic signed [2:0]    dr3, df3;
    logic signed [RW-1:0] cand_r, cand_f;
    logic [SQ_W-1:0]      cand_sq;
    logic                 sliding, on_board, occ_bit, emit, ray_cont, finish, start_rank;
    logic [2:0]           last_idx;

    always_comb begin
        d          = delta(pc, pl, idx);
        dr3        = d[5:3];
        df3        = d[2:0];
        sliding    = (pc == PC_ROOK) || (pc == PC_BISHOP) || (pc == PC_QUEEN);
        // Non-sliding pieces never advance cur, so cur always equals the origin for them.
        cand_r     = cur_r + RW'(dr3);
        cand_f     = cur_f + RW'(df3);
        on_board   = !cand_r[RW-1] && (cand_r < DIM_S) && !cand_f[RW-1] && (cand_f < DIM_S);
        cand_sq    = SQ_W'(cand_r) * DIM_U + SQ_W'(cand_f);
`ifdef MOVE_GEN_BLOCKER_EN
        occ_bit    = on_board && occ[cand_sq];
`else
        occ_bit    = 1'b0;
`endif
        start_rank = pl ? (org_r == START_B) : (org_r == START_W);
        emit       = on_board;
        if (pc == PC_PAWN) begin
            case (idx[1:0])
                2'd0:    emit = on_board && !occ_bit;
                2'd1:    emit = on_board && start_rank && push1_clear && !occ_bit;
                default: emit = on_board && (occ_bit || !CAPT_NEEDS_OCC);
            endcase
        end
        ray_cont   = sliding && on_board && !occ_bit;
        last_idx   = ((pc == PC_ROOK) || (pc == PC_PAWN)) ? 3'd3 : 3'd7;
        finish     = !ray_cont && (idx == last_idx);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            move_valid   <= 1'b0;
            gen_done     <= 1'b0;
            busy         <= 1'b0;
            move_sq      <= '0;
            move_count   <= '0;
            pc           <= '0;
            pl           <= 1'b0;
            org_r        <= '0;
            org_f        <= '0;
            cur_r        <= '0;
            cur_f        <= '0;
            idx          <= '0;
            last_pending <= 1'b0;
            push1_clear  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        move_count  <= '0;
                        pc          <= piece;
                        pl          <= player;
                        org_r       <= RW'(square / DIM_U);
                        org_f       <= RW'(square % DIM_U);
                        cur_r       <= RW'(square / DIM_U);
                        cur_f       <= RW'(square % DIM_U);
                        idx         <= (piece == PC_BISHOP) ? 3'd4 : 3'd0;
                        push1_clear <= 1'b0;
                        if (piece != 4'd0 && piece <= 4'd6) begin
                            state <= WALK;
                        end else begin
                            state    <= DONE;
                            gen_done <= 1'b1;
                        end
                    end
                end
                WALK: begin
                    if (pc == PC_PAWN && idx == 3'd0)
                        push1_clear <= on_board && !occ_bit;
                    if (ray_cont) begin
                        cur_r <= cand_r;
                        cur_f <= cand_f;
                    end else begin
                        cur_r <= org_r;
                        cur_f <= org_f;
                        idx   <= idx + 3'd1;
                    end
                    if (emit) begin
                        move_sq      <= cand_sq;
                        move_valid   <= 1'b1;
                        last_pending <= finish;
                        state        <= EMIT;
                    end else if (finish) begin
                        state    <= DONE;
                        gen_done <= 1'b1;
                    end
                end
                EMIT: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        move_count <= move_count + SQ_W'(1);
                        if (last_pending) begin
                            state    <= DONE;
                            gen_done <= 1'b1;
                        end else begin
                            state <= WALK;
                        end
                    end
                end
                default: begin
                    gen_done  <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_gen_seq.sv
// tb/tb_move_gen_seq.sv - randomized bench for move_gen_seq against a ray-walking reference model
`timescale 1ns/1ps
module tb_move_gen_seq;
    localparam int D  = 8;
    localparam int SW = $clog2(D * D);
`ifdef MOVE_GEN_BLOCKER_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic           clock = 1'b0, reset_n = 1'b0, req_valid = 1'b0, player = 1'b0, move_ready = 1'b0;
    logic [3:0]     piece = 4'd0;
    logic [SW-1:0]  square = '0;
    logic           req_ready, move_valid, gen_done, busy;
    logic [SW-1:0]  move_sq, move_count;
    logic [D*D-1:0] tb_occ = '0;

    int errors = 0, checks = 0;
    int exp_q[$], mdl_q[$], lit_q[$];
    int exp_n = 0;
    bit mon_en = 1'b0, prev_stall = 1'b0;
    int prev_sq = 0;

    int DIR_DR[8] = '{1, 0, -1, 0, 1, -1, -1, 1};
    int DIR_DF[8] = '{0, 1, 0, -1, 1, 1, -1, -1};
    int KN_DR[8]  = '{2, 1, -1, -2, -2, -1, 1, 2};
    int KN_DF[8]  = '{1, 2, 2, 1, -1, -2, -2, -1};

    always #5 clock = ~clock;

    move_gen_seq #(.BOARD_DIM(D)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .piece(piece), .player(player), .square(square),
`ifdef MOVE_GEN_BLOCKER_EN
        .occ(tb_occ),
`endif
        .move_valid(move_valid), .move_ready(move_ready), .move_sq(move_sq),
        .gen_done(gen_done), .move_count(move_count), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit onb(input int r, input int f);
        return r >= 0 && r < D && f >= 0 && f < D;
    endfunction

    function automatic bit occ_at(input int r, input int f);
        return BLK && onb(r, f) && tb_occ[r*D+f];
    endfunction

    task automatic model(input int pc, input int pl, input int sq);
        int r0, f0, r, f, lo, hi, fw;
        mdl_q.delete();
        r0 = sq / D;
        f0 = sq % D;
        if (pc == 2 || pc == 4 || pc == 5) begin
            lo = (pc == 4) ? 4 : 0;
            hi = (pc == 2) ? 3 : 7;
            for (int k = lo; k <= hi; k++) begin
                r = r0 + DIR_DR[k];
                f = f0 + DIR_DF[k];
                while (onb(r, f)) begin
                    mdl_q.push_back(r*D + f);
                    if (occ_at(r, f)) break;
                    r += DIR_DR[k];
                    f += DIR_DF[k];
                end
            end
        end else if (pc == 6) begin
            for (int k = 0; k < 8; k++)
                if (onb(r0 + DIR_DR[k], f0 + DIR_DF[k])) mdl_q.push_back((r0 + DIR_DR[k])*D + f0 + DIR_DF[k]);
        end else if (pc == 3) begin
            for (int k = 0; k < 8; k++)
                if (onb(r0 + KN_DR[k], f0 + KN_DF[k])) mdl_q.push_back((r0 + KN_DR[k])*D + f0 + KN_DF[k]);
        end else if (pc == 1) begin
            fw = pl ? -1 : 1;
            if (onb(r0 + fw, f0) && !occ_at(r0 + fw, f0)) mdl_q.push_back((r0 + fw)*D + f0);
            if (r0 == (pl ? D - 2 : 1) && onb(r0 + 2*fw, f0) && !occ_at(r0 + fw, f0) && !occ_at(r0 + 2*fw, f0))
                mdl_q.push_back((r0 + 2*fw)*D + f0);
            for (int s = -1; s <= 1; s += 2)
                if (onb(r0 + fw, f0 + s) && (!BLK || occ_at(r0 + fw, f0 + s)))
                    mdl_q.push_back((r0 + fw)*D + f0 + s);
        end
    endtask

    task automatic pin(input string name);
        chk({name, "_len"}, mdl_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < mdl_q.size(); i++) chk(name, mdl_q[i], lit_q[i]);
    endtask

    // mode 0: always ready, 1: random ready, 2: five stall cycles per move
    task automatic run_req(input int pc, input int pl, input int sq, input int mode);
        int  n, stall;
        bit  hs, done;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        model(pc, pl, sq);
        exp_q = mdl_q;
        exp_n = mdl_q.size();
        piece = 4'(pc); player = pl[0]; square = SW'(sq); req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        piece = 4'($urandom); player = 1'($urandom); square = SW'($urandom);
        chk("busy_after_accept", busy, 1);
        if (pc < 1 || pc > 6) chk("empty_done_latency", gen_done, 1);
        stall = 0; hs = 1'b0; done = gen_done; n = 0;
        while (!done && n < 1000) begin
            if (hs) stall = 0;
            if (mode == 0) move_ready = 1'b1;
            else if (mode == 1) move_ready = 1'($urandom_range(0, 1));
            else if (move_valid && stall < 5) begin
                move_ready = 1'b0;
                stall++;
            end else move_ready = move_valid;
            hs = move_valid && move_ready;
            @(posedge clock); #1;
            n++;
            done = gen_done;
        end
        chk("gen_done_seen", done, 1);
        @(posedge clock); #1;
        chk("count_hold", move_count, exp_n);
        chk("idle_ready", req_ready, 1);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else if (mon_en) begin
            chk("ready_vs_busy", req_ready, !busy);
            if (prev_stall) begin
                chk("hold_valid", move_valid, 1);
                chk("hold_sq", move_sq, prev_sq);
            end
            if (move_valid && move_ready) begin
                if (exp_q.size() == 0) chk("extra_move", move_sq, -1);
                else chk("move_sq", move_sq, exp_q.pop_front());
            end
            if (gen_done) begin
                chk("done_count", move_count, exp_n);
                chk("done_leftover", exp_q.size(), 0);
                chk("busy_at_done", busy, 1);
            end
            prev_stall <= move_valid && !move_ready;
            prev_sq    <= move_sq;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_move_valid", move_valid, 0);
        chk("rst_gen_done", gen_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_move_sq", move_sq, 0);
        chk("rst_move_count", move_count, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        lit_q = '{8, 16, 24, 32, 40, 48, 56, 1, 2, 3, 4, 5, 6, 7};
        model(2, 0, 0); pin("pin_rook0");
        run_req(2, 0, 0, 0);
        lit_q = '{17, 10};
        model(3, 0, 0); pin("pin_knight0");
        run_req(3, 0, 0, 0);
        lit_q = '{12, 5, 3, 13, 11};
        model(6, 0, 4); pin("pin_king4");
        run_req(6, 0, 4, 1);
        model(5, 0, 27); chk("pin_queen27_len", mdl_q.size(), 27);
        run_req(5, 0, 27, 1);

        tb_occ = '0; tb_occ[19] = 1'b1; tb_occ[21] = 1'b1;
        lit_q = '{20, 28, 19, 21};
        model(1, 0, 12); pin("pin_pawn_w12");
        run_req(1, 0, 12, 0);
        tb_occ = '0; tb_occ[43] = 1'b1; tb_occ[45] = 1'b1;
        lit_q = '{44, 36, 43, 45};
        model(1, 1, 52); pin("pin_pawn_b52");
        run_req(1, 1, 52, 1);
        tb_occ = '0;
        lit_q.delete();
        model(1, 0, 60); pin("pin_pawn_w60");
        run_req(1, 0, 60, 0);
        model(0, 0, 9); pin("pin_empty");
        run_req(0, 0, 9, 0);
        run_req(7, 1, 33, 0);

        run_req(2, 0, 0, 2);
        run_req(6, 1, 36, 2);

        if (BLK) begin
            tb_occ = '0; tb_occ[24] = 1'b1;
            lit_q = '{8, 16, 24, 1, 2, 3, 4, 5, 6, 7};
            model(2, 0, 0); pin("pin_block_rook0");
            run_req(2, 0, 0, 0);
            tb_occ = '0;
        end

        // abort a stalled walk with an asynchronous reset
        model(5, 0, 27);
        exp_q = mdl_q; exp_n = mdl_q.size();
        piece = 4'd5; player = 1'b0; square = SW'(27); move_ready = 1'b0; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_move_valid", move_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_gen_done", gen_done, 0);
        chk("abort_move_sq", move_sq, 0);
        chk("abort_move_count", move_count, 0);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_req(2, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            tb_occ = {$urandom, $urandom} & {$urandom, $urandom};
            run_req($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, D*D-1), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
